dispense_control: RTL and testbench
===================================

Name: dispense_control

Overview:
- Downstream stage of the item selection block: consumes item_selected / no_items_selected / selection_done.
- Looks up price and stock in the item memory, then collects payment credit.
- On sufficient credit: dispenses, writes back the decremented stock, returns change, and pulses dispense_valid back upstream to clear the selection.
- Handles zero quantity, out-of-stock, cancel and payment timeout.

Parameters:
- item_addr, 10: item index width (1024 items).
- no_items_addr, 8: quantity / stock width.
- price_width, 16: unit price width.
- total_width, 24: cost, credit and change width (price_width + no_items_addr).
- pay_timeout, 1000: WAIT_PAY cycles without money_valid before auto-refund.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- selection_done  in  1  one-cycle pulse, new selection valid
- item_selected  in  item_addr  selected item
- no_items_selected  in  no_items_addr  requested quantity
- mem_rd_en  out  1  item memory read strobe
- mem_addr  out  item_addr  read/write address
- mem_rd_price  in  price_width  unit price, valid the cycle after mem_rd_en
- mem_rd_stock  in  no_items_addr  stock, valid the cycle after mem_rd_en
- mem_wr_en  out  1  stock write strobe
- mem_wr_stock  out  no_items_addr  new stock value
- money_valid  in  1  one-cycle credit pulse
- money_amount  in  total_width  credit value
- cancel  in  1  user cancel, level sampled each cycle
- dispense_valid  out  1  one-cycle pulse; item dispensed
- dispense_item  out  item_addr  dispensed item
- dispense_count  out  no_items_addr  dispensed quantity
- change_valid  out  1  one-cycle pulse; return change_amount
- change_amount  out  total_width  change / refund / rejected money
- err_valid  out  1  one-cycle error pulse
- err_code  out  3  1 zero qty, 2 out of stock, 3 timeout, 4 cancel
- sel_dropped  out  1  one-cycle pulse; selection ignored while busy
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low. While rstn=0 at a clk edge:
  - FSM goes to IDLE.
  - All outputs, including err_code, reach 0 on that edge.
  - Credit, timer and latched item/qty/price/stock are cleared.
  - Reset mid-operation discards credit with no refund.
- Output timing: all outputs are registered or decoded from the state register only; no input-to-output combinational path.
- States: IDLE, READ, LOAD, CHECK, WAIT_PAY, DISPENSE, REFUND, ERROR.
- IDLE:
  - selection_done=1: latch item and qty.
  - qty==0: go to ERROR with code 1.
  - Otherwise go to READ.
- READ: mem_rd_en=1, mem_addr=item.
- LOAD: register price and stock; register cost = price*qty, zero-extended to total_width (never overflows).
- CHECK:
  - stock < qty: go to ERROR with code 2.
  - Otherwise go to WAIT_PAY; clear timer and credit.
- WAIT_PAY: credit_next = credit + (money_valid ? money_amount : 0), saturating at all-ones. Transition priority:
  - cancel: REFUND, code 4.
  - timeout (pay_timeout consecutive cycles with no money_valid): REFUND, code 3.
  - credit_next >= cost: DISPENSE.
  - Otherwise stay.
  - The timer clears on every money_valid. Price 0 dispenses with zero credit.
- DISPENSE, one cycle:
  - dispense_valid=1, dispense_item=item, dispense_count=qty.
  - mem_wr_en=1, mem_addr=item, mem_wr_stock = stock - qty.
  - change_valid = (credit > cost), change_amount = credit - cost.
  - Then go to IDLE.
- REFUND, one cycle: err_valid=1; change_valid = (credit != 0), change_amount = credit; then go to IDLE.
- ERROR, one cycle: err_valid=1 with latched code; then go to IDLE. No memory write.
- Latency: selection_done at T gives READ at T+1, LOAD at T+2, CHECK at T+3, WAIT_PAY at T+4. Zero-qty error appears at T+1; out-of-stock error at T+4.
- Money outside WAIT_PAY is rejected: change_valid=1, change_amount=money_amount one cycle later. This never collides with DISPENSE/REFUND change, since both are entered only from WAIT_PAY.
- selection_done when not IDLE: ignored; sel_dropped=1 the next cycle; latched selection unchanged.
- err_code holds its last value between pulses. Other data outputs return to 0 when their valid is low.

Decomposition:
- Package vm_pkg: state enum, err_code constants (ERR_NONE=0, ERR_ZERO_QTY=1, ERR_NO_STOCK=2, ERR_TIMEOUT=3, ERR_CANCEL=4), default widths.
- One sub-module, vm_credit_acc: saturating credit register, timeout counter, reject-echo path. Controls are clear/accept; outputs are credit, credit_next and timeout.
- FSM and memory sequencing stay in dispense_control.

Test Plan:
- Normal purchase, with item 5 price 25, stock 10, qty 3 (cost 75): money 50 then 50 in WAIT_PAY -> DISPENSE with item=5, count=3; mem_wr_stock=7; change_valid with change_amount 25; dispense_valid for exactly one cycle.
- Out of stock, stock 2 and qty 3 -> err_valid with code 2 at T+4; no mem_wr_en; no dispense.
- Zero quantity, qty 0 -> err code 1 at T+1; mem_rd_en never asserted.
- Timeout, pay_timeout=100: money 20 then idle -> REFUND exactly 100 cycles after the money pulse, with change 20 and err code 3.
- Cancel on the same cycle as the final coin that would cover cost -> REFUND with full credit and code 4; no dispense. Money 10 in IDLE -> change_valid with 10 next cycle. selection_done in WAIT_PAY -> sel_dropped pulse.
- Reset, rstn=0 mid-WAIT_PAY with credit 40 -> next edge all outputs 0 and busy=0; no change pulse; a new selection proceeds normally.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types, error codes and default widths for the vending dispense path.
package vm_pkg;

    localparam int unsigned DefItemAddr    = 10;
    localparam int unsigned DefNoItemsAddr = 8;
    localparam int unsigned DefPriceWidth  = 16;
    localparam int unsigned DefTotalWidth  = 24;
    localparam int unsigned DefPayTimeout  = 1000;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLoad,
        StCheck,
        StWaitPay,
        StDispense,
        StRefund,
        StError
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ZERO_QTY = 3'd1;
    localparam logic [2:0] ERR_NO_STOCK = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
    localparam logic [2:0] ERR_CANCEL   = 3'd4;

endpackage

// File: rtl/vm_credit_acc.sv
// Saturating payment credit, payment inactivity timer and echo of money
// arriving while payment is not being accepted.
module vm_credit_acc
    import vm_pkg::*;
#(
    parameter int unsigned total_width = DefTotalWidth,
    parameter int unsigned pay_timeout = DefPayTimeout
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clear,
    input  logic                   accept,
    input  logic                   money_valid,
    input  logic [total_width-1:0] money_amount,
    output logic [total_width-1:0] credit,
    output logic [total_width-1:0] credit_next,
    output logic                   timeout,
    output logic                   rej_valid,
    output logic [total_width-1:0] rej_amount
);

    localparam int unsigned TimerW = $clog2(pay_timeout + 1);

    logic [total_width-1:0] credit_q;
    logic [TimerW-1:0]      timer_q;
    logic                   rej_valid_q;
    logic [total_width-1:0] rej_amount_q;
    logic [total_width-1:0] add;
    logic [total_width:0]   sum;

    always_comb begin
        add         = money_valid ? money_amount : '0;
        sum         = {1'b0, credit_q} + {1'b0, add};
        credit_next = sum[total_width] ? '1 : sum[total_width-1:0];
    end

    // Fires on the pay_timeout-th consecutive accepting cycle without money.
    assign timeout = accept && !money_valid && (timer_q == TimerW'(pay_timeout - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            credit_q     <= '0;
            timer_q      <= '0;
            rej_valid_q  <= 1'b0;
            rej_amount_q <= '0;
        end else begin
            if (clear) begin
                credit_q <= '0;
            end else if (accept) begin
                credit_q <= credit_next;
            end
            if (clear || (accept && money_valid)) begin
                timer_q <= '0;
            end else if (accept) begin
                timer_q <= timer_q + TimerW'(1);
            end
            rej_valid_q  <= money_valid && !accept;
            rej_amount_q <= (money_valid && !accept) ? money_amount : '0;
        end
    end

    assign credit     = credit_q;
    assign rej_valid  = rej_valid_q;
    assign rej_amount = rej_amount_q;

endmodule

// File: rtl/dispense_control.sv
// Dispense sequencer: reads price/stock for a selection, collects payment,
// then dispenses with stock write-back and change, or refunds/flags an error.
module dispense_control
    import vm_pkg::*;
#(
    parameter int unsigned item_addr     = DefItemAddr,
    parameter int unsigned no_items_addr = DefNoItemsAddr,
    parameter int unsigned price_width   = DefPriceWidth,
    parameter int unsigned total_width   = DefTotalWidth,
    parameter int unsigned pay_timeout   = DefPayTimeout
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     selection_done,
    input  logic [item_addr-1:0]     item_selected,
    input  logic [no_items_addr-1:0] no_items_selected,
    output logic                     mem_rd_en,
    output logic [item_addr-1:0]     mem_addr,
    input  logic [price_width-1:0]   mem_rd_price,
    input  logic [no_items_addr-1:0] mem_rd_stock,
    output logic                     mem_wr_en,
    output logic [no_items_addr-1:0] mem_wr_stock,
    input  logic                     money_valid,
    input  logic [total_width-1:0]   money_amount,
    input  logic                     cancel,
    output logic                     dispense_valid,
    output logic [item_addr-1:0]     dispense_item,
    output logic [no_items_addr-1:0] dispense_count,
    output logic                     change_valid,
    output logic [total_width-1:0]   change_amount,
    output logic                     err_valid,
    output logic [2:0]               err_code,
    output logic                     sel_dropped,
    output logic                     busy
);

    state_e                   state_q, state_d;
    logic [2:0]               err_code_q, err_code_d;
    logic [item_addr-1:0]     item_q;
    logic [no_items_addr-1:0] qty_q;
    logic [no_items_addr-1:0] stock_q;
    logic [total_width-1:0]   cost_q;
    logic                     sel_dropped_q;

    logic                     acc_clear;
    logic                     acc_accept;
    logic [total_width-1:0]   credit;
    logic [total_width-1:0]   credit_next;
    logic                     timeout;
    logic                     rej_valid;
    logic [total_width-1:0]   rej_amount;

    assign acc_clear  = (state_q == StCheck);
    assign acc_accept = (state_q == StWaitPay);

    vm_credit_acc #(
        .total_width (total_width),
        .pay_timeout (pay_timeout)
    ) u_credit_acc (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (acc_clear),
        .accept       (acc_accept),
        .money_valid  (money_valid),
        .money_amount (money_amount),
        .credit       (credit),
        .credit_next  (credit_next),
        .timeout      (timeout),
        .rej_valid    (rej_valid),
        .rej_amount   (rej_amount)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= StIdle;
            err_code_q    <= ERR_NONE;
            item_q        <= '0;
            qty_q         <= '0;
            stock_q       <= '0;
            cost_q        <= '0;
            sel_dropped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_code_q    <= err_code_d;
            sel_dropped_q <= selection_done && (state_q != StIdle);
            if (state_q == StIdle && selection_done) begin
                item_q <= item_selected;
                qty_q  <= no_items_selected;
            end
            if (state_q == StLoad) begin
                stock_q <= mem_rd_stock;
                // price * qty fits total_width by construction
                cost_q  <= total_width'(mem_rd_price) * total_width'(qty_q);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        unique case (state_q)
            StIdle: begin
                if (selection_done) begin
                    if (no_items_selected == '0) begin
                        state_d    = StError;
                        err_code_d = ERR_ZERO_QTY;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = StLoad;
            StLoad:  state_d = StCheck;
            StCheck: begin
                if (stock_q < qty_q) begin
                    state_d    = StError;
                    err_code_d = ERR_NO_STOCK;
                end else begin
                    state_d = StWaitPay;
                end
            end
            StWaitPay: begin
                if (cancel) begin
                    state_d    = StRefund;
                    err_code_d = ERR_CANCEL;
                end else if (timeout) begin
                    state_d    = StRefund;
                    err_code_d = ERR_TIMEOUT;
                end else if (credit_next >= cost_q) begin
                    state_d = StDispense;
                end
            end
            StDispense: state_d = StIdle;
            StRefund:   state_d = StIdle;
            StError:    state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_rd_en      = (state_q == StRead);
        mem_wr_en      = (state_q == StDispense);
        mem_addr       = '0;
        mem_wr_stock   = '0;
        dispense_valid = (state_q == StDispense);
        dispense_item  = '0;
        dispense_count = '0;
        err_valid      = (state_q == StRefund) || (state_q == StError);
        change_valid   = 1'b0;
        change_amount  = '0;
        if (state_q == StRead || state_q == StDispense) begin
            mem_addr = item_q;
        end
        if (state_q == StDispense) begin
            mem_wr_stock   = stock_q - qty_q;
            dispense_item  = item_q;
            dispense_count = qty_q;
        end
        // Rejected money is only echoed outside payment, so it cannot overlap
        // a dispense or refund change return.
        if (rej_valid) begin
            change_valid  = 1'b1;
            change_amount = rej_amount;
        end else if (state_q == StDispense && credit > cost_q) begin
            change_valid  = 1'b1;
            change_amount = credit - cost_q;
        end else if (state_q == StRefund && credit != '0) begin
            change_valid  = 1'b1;
            change_amount = credit;
        end
    end

    assign err_code    = err_code_q;
    assign sel_dropped = sel_dropped_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_dispense_control.sv
// Directed bench for dispense_control with a small behavioural item memory.
module tb_dispense_control;
    import vm_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        selection_done = 1'b0;
    logic [9:0]  item_selected = '0;
    logic [7:0]  no_items_selected = '0;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rd_price = '0;
    logic [7:0]  mem_rd_stock = '0;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_stock;
    logic        money_valid = 1'b0;
    logic [23:0] money_amount = '0;
    logic        cancel = 1'b0;
    logic        dispense_valid;
    logic [9:0]  dispense_item;
    logic [7:0]  dispense_count;
    logic        change_valid;
    logic [23:0] change_amount;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        sel_dropped;
    logic        busy;

    logic [15:0] ptab [1024];
    logic [7:0]  stab [1024];
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int disp_cnt = 0;
    int chg_cnt = 0;

    dispense_control #(
        .pay_timeout (100)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .selection_done    (selection_done),
        .item_selected     (item_selected),
        .no_items_selected (no_items_selected),
        .mem_rd_en         (mem_rd_en),
        .mem_addr          (mem_addr),
        .mem_rd_price      (mem_rd_price),
        .mem_rd_stock      (mem_rd_stock),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_stock      (mem_wr_stock),
        .money_valid       (money_valid),
        .money_amount      (money_amount),
        .cancel            (cancel),
        .dispense_valid    (dispense_valid),
        .dispense_item     (dispense_item),
        .dispense_count    (dispense_count),
        .change_valid      (change_valid),
        .change_amount     (change_amount),
        .err_valid         (err_valid),
        .err_code          (err_code),
        .sel_dropped       (sel_dropped),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Item memory: one-cycle read latency, write on strobe; plus event counters.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_price <= ptab[mem_addr];
            mem_rd_stock <= stab[mem_addr];
            rd_cnt       <= rd_cnt + 1;
        end
        if (mem_wr_en) begin
            stab[mem_addr] <= mem_wr_stock;
            wr_cnt         <= wr_cnt + 1;
        end
        if (dispense_valid) disp_cnt <= disp_cnt + 1;
        if (change_valid) chg_cnt <= chg_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input logic [9:0] it, input logic [7:0] q);
        selection_done    = 1'b1;
        item_selected     = it;
        no_items_selected = q;
        tick();
        selection_done    = 1'b0;
    endtask

    task automatic pay(input logic [23:0] amt);
        money_valid  = 1'b1;
        money_amount = amt;
        tick();
        money_valid  = 1'b0;
        money_amount = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        checks++; if ({mem_rd_en, mem_addr, mem_wr_en, mem_wr_stock, dispense_valid, dispense_item,
                       dispense_count, change_valid, change_amount, err_valid, sel_dropped} !== '0)
            begin errors++; $display("FAIL reset_outputs: got nonzero output vector, want 0"); end
        checks++; if (busy !== 1'b0)
            begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (err_code !== 3'd0)
            begin errors++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reject();
        pay(24'd10);
        checks++; if (change_valid !== 1'b1 || change_amount !== 24'd10)
            begin errors++; $display("FAIL reject_echo: got v=%b amt=%0d want v=1 amt=10",
                                     change_valid, change_amount); end
        checks++; if (busy !== 1'b0)
            begin errors++; $display("FAIL reject_busy: got %b want 0", busy); end
        tick();
        checks++; if (change_valid !== 1'b0 || change_amount !== 24'd0)
            begin errors++; $display("FAIL reject_clear: got v=%b amt=%0d want 0",
                                     change_valid, change_amount); end
    endtask

    task automatic test_purchase();
        ptab[5] = 16'd25;
        stab[5] = 8'd10;
        select(10'd5, 8'd3);
        checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 10'd5 || busy !== 1'b1)
            begin errors++; $display("FAIL buy_read: got rd=%b addr=%0d busy=%b want 1 5 1",
                                     mem_rd_en, mem_addr, busy); end
        tick(); tick(); tick();
        pay(24'd50);
        checks++; if (dispense_valid !== 1'b0)
            begin errors++; $display("FAIL buy_early: got dispense=%b want 0", dispense_valid); end
        pay(24'd50);
        checks++; if (dispense_valid !== 1'b1 || dispense_item !== 10'd5 || dispense_count !== 8'd3)
            begin errors++; $display("FAIL buy_dispense: got v=%b item=%0d cnt=%0d want 1 5 3",
                                     dispense_valid, dispense_item, dispense_count); end
        checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 10'd5 || mem_wr_stock !== 8'd7)
            begin errors++; $display("FAIL buy_write: got we=%b addr=%0d stock=%0d want 1 5 7",
                                     mem_wr_en, mem_addr, mem_wr_stock); end
        checks++; if (change_valid !== 1'b1 || change_amount !== 24'd25)
            begin errors++; $display("FAIL buy_change: got v=%b amt=%0d want 1 25",
                                     change_valid, change_amount); end
        tick();
        checks++; if (dispense_valid !== 1'b0 || change_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL buy_after: got disp=%b chg=%b busy=%b want 0 0 0",
                                     dispense_valid, change_valid, busy); end
        checks++; if (stab[5] !== 8'd7)
            begin errors++; $display("FAIL buy_stock_mem: got %0d want 7", stab[5]); end
    endtask

    task automatic test_no_stock();
        int wr0, d0;
        wr0 = wr_cnt;
        d0  = disp_cnt;
        ptab[7] = 16'd10;
        stab[7] = 8'd2;
        select(10'd7, 8'd3);
        tick(); tick();
        checks++; if (err_valid !== 1'b0)
            begin errors++; $display("FAIL nostock_early: got err=%b at T+3 want 0", err_valid); end
        tick();
        checks++; if (err_valid !== 1'b1 || err_code !== ERR_NO_STOCK)
            begin errors++; $display("FAIL nostock_err: got v=%b code=%0d want 1 2",
                                     err_valid, err_code); end
        tick();
        checks++; if (busy !== 1'b0 || err_valid !== 1'b0 || err_code !== ERR_NO_STOCK)
            begin errors++; $display("FAIL nostock_after: got busy=%b v=%b code=%0d want 0 0 2",
                                     busy, err_valid, err_code); end
        checks++; if (wr_cnt !== wr0 || disp_cnt !== d0)
            begin errors++; $display("FAIL nostock_side: got writes=%0d disp=%0d want %0d %0d",
                                     wr_cnt, disp_cnt, wr0, d0); end
    endtask

    task automatic test_zero_qty();
        int rd0;
        rd0 = rd_cnt;
        select(10'd3, 8'd0);
        checks++; if (err_valid !== 1'b1 || err_code !== ERR_ZERO_QTY || mem_rd_en !== 1'b0)
            begin errors++; $display("FAIL zero_err: got v=%b code=%0d rd=%b want 1 1 0",
                                     err_valid, err_code, mem_rd_en); end
        tick();
        checks++; if (busy !== 1'b0 || rd_cnt !== rd0)
            begin errors++; $display("FAIL zero_after: got busy=%b reads=%0d want 0 %0d",
                                     busy, rd_cnt, rd0); end
    endtask

    task automatic test_timeout();
        int n;
        ptab[9] = 16'd100;
        stab[9] = 8'd5;
        select(10'd9, 8'd1);
        tick(); tick(); tick();
        pay(24'd20);
        // n counts clock edges after the edge that sampled the money pulse
        n = 0;
        while (err_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checks++; if (n !== 100)
            begin errors++; $display("FAIL timeout_latency: got %0d edges want 100", n); end
        checks++; if (err_code !== ERR_TIMEOUT || change_valid !== 1'b1 || change_amount !== 24'd20)
            begin errors++; $display("FAIL timeout_refund: got code=%0d v=%b amt=%0d want 3 1 20",
                                     err_code, change_valid, change_amount); end
        tick();
    endtask

    task automatic test_cancel();
        int d0;
        d0 = disp_cnt;
        select(10'd5, 8'd2);
        tick(); tick(); tick();
        pay(24'd30);
        cancel = 1'b1;
        pay(24'd20);
        cancel = 1'b0;
        checks++; if (err_valid !== 1'b1 || err_code !== ERR_CANCEL)
            begin errors++; $display("FAIL cancel_err: got v=%b code=%0d want 1 4",
                                     err_valid, err_code); end
        checks++; if (change_valid !== 1'b1 || change_amount !== 24'd50 || dispense_valid !== 1'b0)
            begin errors++; $display("FAIL cancel_refund: got v=%b amt=%0d disp=%b want 1 50 0",
                                     change_valid, change_amount, dispense_valid); end
        tick();
        checks++; if (busy !== 1'b0 || disp_cnt !== d0)
            begin errors++; $display("FAIL cancel_after: got busy=%b disp=%0d want 0 %0d",
                                     busy, disp_cnt, d0); end
    endtask

    task automatic test_sel_drop();
        select(10'd5, 8'd1);
        tick(); tick(); tick();
        select(10'd9, 8'd4);
        checks++; if (sel_dropped !== 1'b1)
            begin errors++; $display("FAIL drop_pulse: got %b want 1", sel_dropped); end
        tick();
        checks++; if (sel_dropped !== 1'b0)
            begin errors++; $display("FAIL drop_clear: got %b want 0", sel_dropped); end
        pay(24'd25);
        checks++; if (dispense_valid !== 1'b1 || dispense_item !== 10'd5 || dispense_count !== 8'd1 ||
                      mem_wr_stock !== 8'd6 || change_valid !== 1'b0)
            begin errors++; $display("FAIL drop_keep: got v=%b item=%0d cnt=%0d stock=%0d chg=%b want 1 5 1 6 0",
                                     dispense_valid, dispense_item, dispense_count, mem_wr_stock,
                                     change_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        int c0;
        select(10'd5, 8'd2);
        tick(); tick(); tick();
        pay(24'd40);
        c0 = chg_cnt;
        rstn = 1'b0;
        tick();
        checks++; if ({mem_rd_en, mem_addr, mem_wr_en, mem_wr_stock, dispense_valid, dispense_item,
                       dispense_count, change_valid, change_amount, err_valid, err_code, sel_dropped,
                       busy} !== '0)
            begin errors++; $display("FAIL midreset_outputs: got nonzero output vector, want 0"); end
        rstn = 1'b1;
        tick(); tick();
        checks++; if (chg_cnt !== c0)
            begin errors++; $display("FAIL midreset_norefund: got %0d change pulses want %0d",
                                     chg_cnt, c0); end
        select(10'd5, 8'd2);
        tick(); tick(); tick();
        pay(24'd50);
        checks++; if (dispense_valid !== 1'b1 || mem_wr_stock !== 8'd4 || change_valid !== 1'b0)
            begin errors++; $display("FAIL midreset_rebuy: got v=%b stock=%0d chg=%b want 1 4 0",
                                     dispense_valid, mem_wr_stock, change_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_reject();
        test_purchase();
        test_no_stock();
        test_zero_qty();
        test_timeout();
        test_cancel();
        test_sel_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
